// File: rtl/nonce_sched_pkg.sv
// Shared state encoding and constants for the nonce scheduler.
// Imported by nonce_scheduler and target_compare.
package nonce_sched_pkg;

  localparam int NONCE_W  = 32;
  localparam int DIGEST_W = 256;

  localparam logic [31:0] NONCE_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DRAIN  = 3'd6,
    ST_DONE   = 3'd7
  } sched_state_t;

endpackage

// File: rtl/nonce_scheduler_target_compare.sv
// Registered unsigned digest <= target compare, captured when the hash core
// reports a result; the flag holds until the next result.
module target_compare
  import nonce_sched_pkg::*;
#(
  parameter int DW = DIGEST_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic [DW-1:0] i_digest,
  input  logic [DW-1:0] i_target,
  output logic          o_hit
);

  logic r_hit;

  // Capture the compare result alongside the digest strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit <= 1'b0;
    end else if (i_en) begin
      r_hit <= (i_digest <= i_target);
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce search controller: clears/steps the incrementer, feeds the hash core and
// checks digests against the target. Build option NONCE_SCHED_MULTI_HIT_EN keeps searching after hits.
module nonce_scheduler #(
  parameter int NONCE_W  = nonce_sched_pkg::NONCE_W,
  parameter int DIGEST_W = nonce_sched_pkg::DIGEST_W
`ifdef NONCE_SCHED_MULTI_HIT_EN
  ,
  parameter int FOUND_CNT_W = 8
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [DIGEST_W-1:0]    i_target,
  input  logic [NONCE_W-1:0]     i_nonce_in,
  output logic                   o_nonce_update,
  output logic                   o_nonce_clear,
  output logic                   o_hash_start,
  output logic [NONCE_W-1:0]     o_hash_nonce,
  input  logic                   i_hash_done,
  input  logic [DIGEST_W-1:0]    i_hash_digest,
  output logic                   o_busy,
  output logic                   o_found,
  output logic [NONCE_W-1:0]     o_golden_nonce,
  output logic                   o_exhausted
`ifdef NONCE_SCHED_MULTI_HIT_EN
  ,
  output logic [FOUND_CNT_W-1:0] o_found_count
`endif
);

  import nonce_sched_pkg::*;

  sched_state_t          r_state;
  logic                  r_last;
  logic                  r_nonce_update;
  logic                  r_nonce_clear;
  logic                  r_hash_start;
  logic [NONCE_W-1:0]    r_hash_nonce;
  logic                  r_busy;
  logic                  r_found;
  logic [NONCE_W-1:0]    r_golden_nonce;
  logic                  r_exhausted;
`ifdef NONCE_SCHED_MULTI_HIT_EN
  logic [FOUND_CNT_W-1:0] r_found_count;
`endif

  logic w_hit;
  logic w_at_max;

  assign w_at_max = (i_nonce_in == NONCE_W'(NONCE_MAX));

  target_compare #(
    .DW (DIGEST_W)
  ) u_target_compare (
    .clk      (clk),
    .reset    (reset),
    .i_en     (i_hash_done),
    .i_digest (i_hash_digest),
    .i_target (i_target),
    .o_hit    (w_hit)
  );

  // Search FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_last         <= 1'b0;
      r_nonce_update <= 1'b0;
      r_nonce_clear  <= 1'b0;
      r_hash_start   <= 1'b0;
      r_hash_nonce   <= '0;
      r_busy         <= 1'b0;
      r_found        <= 1'b0;
      r_golden_nonce <= '0;
      r_exhausted    <= 1'b0;
`ifdef NONCE_SCHED_MULTI_HIT_EN
      r_found_count  <= '0;
`endif
    end else begin
      r_nonce_update <= 1'b0;
      r_nonce_clear  <= 1'b0;
      r_hash_start   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_found        <= 1'b0;
            r_exhausted    <= 1'b0;
            r_golden_nonce <= '0;
`ifdef NONCE_SCHED_MULTI_HIT_EN
            r_found_count  <= '0;
`endif
            r_nonce_clear  <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (!i_enable) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!i_enable) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_hash_nonce   <= i_nonce_in;
            r_hash_start   <= 1'b1;
            r_nonce_update <= !w_at_max;
            r_last         <= w_at_max;
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!i_enable) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        // A result arriving in the same cycle enable drops needs no drain.
        ST_WAIT: begin
          if (!i_enable) begin
            if (i_hash_done) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (i_hash_done) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!i_enable) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
`ifdef NONCE_SCHED_MULTI_HIT_EN
            if (w_hit) begin
              r_golden_nonce <= r_hash_nonce;
              r_found        <= 1'b1;
              if (r_found_count != {FOUND_CNT_W{1'b1}}) begin
                r_found_count <= r_found_count + FOUND_CNT_W'(1);
              end
            end
            if (r_last) begin
              r_exhausted <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_hash_nonce   <= i_nonce_in;
              r_hash_start   <= 1'b1;
              r_nonce_update <= !w_at_max;
              r_last         <= w_at_max;
              r_state        <= ST_ISSUE;
            end
`else
            if (w_hit) begin
              r_golden_nonce <= r_hash_nonce;
              r_found        <= 1'b1;
              r_exhausted    <= r_last;
              r_busy         <= 1'b0;
              r_state        <= ST_DONE;
            end else if (r_last) begin
              r_exhausted <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_hash_nonce   <= i_nonce_in;
              r_hash_start   <= 1'b1;
              r_nonce_update <= !w_at_max;
              r_last         <= w_at_max;
              r_state        <= ST_ISSUE;
            end
`endif
          end
        end
        ST_DRAIN: begin
          if (i_hash_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_nonce_update = r_nonce_update;
  assign o_nonce_clear  = r_nonce_clear;
  assign o_hash_start   = r_hash_start;
  assign o_hash_nonce   = r_hash_nonce;
  assign o_busy         = r_busy;
  assign o_found        = r_found;
  assign o_golden_nonce = r_golden_nonce;
  assign o_exhausted    = r_exhausted;
`ifdef NONCE_SCHED_MULTI_HIT_EN
  assign o_found_count  = r_found_count;
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler with an incrementer model and an L=4 stub hasher.
// Expected hash_start nonces and end-of-search results are queued by the stimulus and checked by a monitor.
module tb_nonce_scheduler;

  localparam int L = 4;
  localparam logic [255:0] TGT = {64'h0000_0000_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
                                  64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};

  typedef struct {
    bit          found;
    bit          exh;
    logic [31:0] golden;
    int          upd;
    int          gap;
    int          fc;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [255:0] target;
  logic [31:0]  nonce_in;
  logic         nonce_update;
  logic         nonce_clear;
  logic         hash_start;
  logic [31:0]  hash_nonce;
  logic         hash_done = 1'b0;
  logic [255:0] hash_digest = '0;
  logic         busy;
  logic         found;
  logic [31:0]  golden_nonce;
  logic         exhausted;
`ifdef NONCE_SCHED_MULTI_HIT_EN
  logic [7:0]   found_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cyc = 0;
  int last_done_cyc = -1;
  int rst_cyc = 0;
  int n_res = 0;
  int n_upd = 0;
  bit first_pending = 1'b0;
  logic prev_busy = 1'b0;

  logic [31:0] exp_start_q[$];
  res_t        exp_res_q[$];
  logic [31:0] hit_list[$];
  logic [31:0] mon_exp_n;
  res_t        mon_r;

  logic [31:0] preload = 32'h0;
  logic [31:0] inc_r = 32'h0;
  logic [31:0] stub_nonce = 32'h0;
  int          stub_cnt = 0;

  nonce_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (enable),
    .i_target       (target),
    .i_nonce_in     (nonce_in),
    .o_nonce_update (nonce_update),
    .o_nonce_clear  (nonce_clear),
    .o_hash_start   (hash_start),
    .o_hash_nonce   (hash_nonce),
    .i_hash_done    (hash_done),
    .i_hash_digest  (hash_digest),
    .o_busy         (busy),
    .o_found        (found),
    .o_golden_nonce (golden_nonce),
    .o_exhausted    (exhausted)
`ifdef NONCE_SCHED_MULTI_HIT_EN
    ,
    .o_found_count  (found_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_hit(input logic [31:0] n);
    foreach (hit_list[i]) if (hit_list[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Incrementer model driven by the scheduler's clear/update pulses.
  always @(posedge clk) begin
    if (nonce_clear === 1'b1) inc_r <= preload;
    else if (nonce_update === 1'b1) inc_r <= inc_r + 32'd1;
  end
  assign nonce_in = inc_r;

  // Stub hasher: result L cycles after hash_start; hit nonces return digest == target.
  always @(posedge clk) begin
    hash_done <= 1'b0;
    if (hash_start === 1'b1) begin
      stub_nonce <= hash_nonce;
      stub_cnt   <= L;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        hash_done   <= 1'b1;
        hash_digest <= is_hit(stub_nonce) ? TGT : TGT + 256'd1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start, result or end of search.
  always @(negedge clk) begin
    if (hash_start === 1'b1) begin
      if (exp_start_q.size() == 0) begin
        chk("unexpected_start", {32'h0, hash_nonce}, 64'hDEAD_0000_0000_0000);
      end else begin
        mon_exp_n = exp_start_q.pop_front();
        chk("hash_nonce", {32'h0, hash_nonce}, {32'h0, mon_exp_n});
      end
      if (first_pending) begin
        first_pending = 1'b0;
        chk("start_latency", 64'(cyc - en_cyc), 64'd3);
      end else if (last_done_cyc >= 0) begin
        chk("issue_interval", 64'(cyc - last_done_cyc), 64'd2);
      end
    end
    if (hash_done === 1'b1) begin
      last_done_cyc = cyc;
      if (busy === 1'b1) chk("hash_nonce_stable", {32'h0, hash_nonce}, {32'h0, stub_nonce});
    end
    if (nonce_update === 1'b1) begin
      chk("update_not_at_max", 64'(nonce_in === 32'hFFFF_FFFF), 64'd0);
      n_upd++;
    end
    if (nonce_clear === 1'b1) n_upd = 0;
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      n_res++;
      if (exp_res_q.size() == 0) begin
        chk("unexpected_end", 64'd1, 64'd0);
      end else begin
        mon_r = exp_res_q.pop_front();
        chk("found", 64'(found), 64'(mon_r.found));
        chk("exhausted", 64'(exhausted), 64'(mon_r.exh));
        chk("golden_nonce", {32'h0, golden_nonce}, {32'h0, mon_r.golden});
        if (mon_r.upd >= 0) chk("update_count", 64'(n_upd), 64'(mon_r.upd));
        if (mon_r.gap >= 0) chk("end_after_done", 64'(cyc - last_done_cyc), 64'(mon_r.gap));
`ifdef NONCE_SCHED_MULTI_HIT_EN
        chk("found_count", 64'(found_count), 64'(mon_r.fc));
`endif
      end
    end
    prev_busy = busy;
  end

  task automatic push_starts(input logic [31:0] first, input int count);
    for (int i = 0; i < count; i++) exp_start_q.push_back(first + 32'(i));
  endtask

  task automatic push_res(input bit f, input bit e, input logic [31:0] g, input int u, input int gp, input int fc);
    res_t r;
    r.found = f; r.exh = e; r.golden = g; r.upd = u; r.gap = gp; r.fc = fc;
    exp_res_q.push_back(r);
  endtask

  task automatic start_run(input logic [31:0] pre);
    preload = pre;
    @(posedge clk);
    #1;
    last_done_cyc = -1;
    first_pending = 1'b1;
    en_cyc = cyc;
    enable = 1'b1;
  endtask

  task automatic stop_run();
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_result(input string name, input int bound);
    int n0 = n_res;
    int k = 0;
    while (n_res == n0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (n_res == n0) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_starts(input string name, input int bound);
    int k = 0;
    while (exp_start_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (exp_start_q.size() != 0) chk({name, "_start_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    target = TGT;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_exhausted", 64'(exhausted), 64'd0);
    chk("rst_golden", {32'h0, golden_nonce}, 64'd0);
    chk("rst_hash_nonce", {32'h0, hash_nonce}, 64'd0);
    chk("rst_pulses", {61'h0, hash_start, nonce_update, nonce_clear}, 64'd0);

    // Drop enable while waiting on nonce 3: drain, then idle one cycle after hash_done.
    hit_list = {};
    push_starts(32'h0, 4);
    push_res(1'b0, 1'b0, 32'h0, 4, 1, 0);
    start_run(32'h0);
    wait_starts("drop", 200);
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    wait_result("drop", 100);
    repeat (10) @(posedge clk);

`ifndef NONCE_SCHED_MULTI_HIT_EN
    // Restart from nonce 4 in the incrementer: clear brings it back to 0; hit on nonce 5.
    hit_list = {32'h5};
    push_starts(32'h0, 6);
    push_res(1'b1, 1'b0, 32'h5, 6, 2, 0);
    start_run(32'h0);
    wait_result("hit5", 300);
    repeat (20) @(posedge clk);
    stop_run();
`else
    // Hits at index 2 and 7 of a ten-nonce window ending at all-ones.
    hit_list = {32'hFFFF_FFF8, 32'hFFFF_FFFD};
    push_starts(32'hFFFF_FFF6, 10);
    push_res(1'b1, 1'b1, 32'hFFFF_FFFD, 9, 2, 2);
    start_run(32'hFFFF_FFF6);
    wait_result("multi", 400);
    repeat (20) @(posedge clk);
    stop_run();
`endif

    // Exhaustion from FFFFFFFE with no hits.
    hit_list = {};
    push_starts(32'hFFFF_FFFE, 2);
    push_res(1'b0, 1'b1, 32'h0, 1, 2, 0);
    start_run(32'hFFFF_FFFE);
    wait_result("exhaust", 200);
    repeat (20) @(posedge clk);
    stop_run();

    // Hit on the very last nonce: found and exhausted together.
    hit_list = {32'hFFFF_FFFF};
    push_starts(32'hFFFF_FFFE, 2);
    push_res(1'b1, 1'b1, 32'hFFFF_FFFF, 1, 2, 1);
    start_run(32'hFFFF_FFFE);
    wait_result("last_hit", 200);
    repeat (20) @(posedge clk);
    stop_run();

    // Reset while waiting on nonce 1; the stale hash_done must be ignored.
    hit_list = {};
    push_starts(32'h0, 2);
    push_res(1'b0, 1'b0, 32'h0, -1, -1, 0);
    start_run(32'h0);
    wait_starts("reset", 200);
    @(posedge clk);
    #1;
    reset = 1'b1;
    enable = 1'b0;
    rst_cyc = cyc;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("stale_done_seen", 64'(last_done_cyc > rst_cyc), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_found", 64'(found), 64'd0);
    chk("post_rst_exhausted", 64'(exhausted), 64'd0);
    chk("post_rst_golden", {32'h0, golden_nonce}, 64'd0);
    chk("post_rst_hash_nonce", {32'h0, hash_nonce}, 64'd0);
`ifdef NONCE_SCHED_MULTI_HIT_EN
    chk("post_rst_found_count", 64'(found_count), 64'd0);
`endif

    chk("start_queue_empty", 64'(exp_start_q.size()), 64'd0);
    chk("result_queue_empty", 64'(exp_res_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
